// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream interface.
// Define ADDSUB_SAT_EN to saturate the result to the signed range on overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic              adv;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  r_q   [STAGES];

  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_c;
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_r [STAGES];

  logic [STAGES-1:0] nx_c;
  logic [WIDTH-1:0]  nx_r  [STAGES];
  logic [SW:0]       part  [STAGES];
  logic              ovf_nx;
  logic [WIDTH-1:0]  fin_sum;

  // One global advance enable: every stage moves together or holds together.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  // Stage inputs: stage 0 sees the port operands, later stages see the skew registers.
  always_comb begin
    stg_v    = '0;
    stg_c    = '0;
    for (int k = 0; k < STAGES; k++) begin
      stg_a[k] = '0;
      stg_b[k] = '0;
      stg_r[k] = '0;
    end
    stg_v[0] = in_valid;
    stg_a[0] = a;
    stg_b[0] = sub ? ~b : b;
    stg_c[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      stg_v[k] = v_q[k-1];
      stg_c[k] = c_q[k-1];
      stg_a[k] = a_q[k-1];
      stg_b[k] = b_q[k-1];
      stg_r[k] = r_q[k-1];
    end
  end

  // Each stage ripples its own slice and merges it into the partial result.
  always_comb begin
    nx_c    = '0;
    ovf_nx  = 1'b0;
    fin_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      part[k] = (SW+1)'(stg_a[k][k*SW +: SW]) + (SW+1)'(stg_b[k][k*SW +: SW])
              + (SW+1)'(stg_c[k]);
      nx_c[k] = part[k][SW];
      nx_r[k] = stg_r[k];
      nx_r[k][k*SW +: SW] = part[k][SW-1:0];
    end
    ovf_nx  = (stg_a[LAST][WIDTH-1] == stg_b[LAST][WIDTH-1])
            & (nx_r[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (ovf_nx)
      fin_sum = stg_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    else
      fin_sum = nx_r[LAST];
`else
    fin_sum = nx_r[LAST];
`endif
  end

  // Pipeline registers; the final stage zeroes data and flags for bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (adv) begin
      v_q   <= stg_v;
      ovf_q <= stg_v[LAST] & ovf_nx;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= stg_a[k];
        b_q[k] <= stg_b[k];
        if (k == int'(LAST)) begin
          r_q[k] <= stg_v[LAST] ? fin_sum : '0;
          c_q[k] <= stg_v[LAST] & nx_c[LAST];
        end else begin
          r_q[k] <= nx_r[k];
          c_q[k] <= nx_c[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4); honours ADDSUB_SAT_EN.
module tb_pipelined_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] X_PADD = 16'h7FFF;
  localparam logic [15:0] X_NSUB = 16'h8000;
  localparam logic [15:0] X_NADD = 16'h8000;
`else
  localparam logic [15:0] X_PADD = 16'h8000;
  localparam logic [15:0] X_NSUB = 16'h7FFF;
  localparam logic [15:0] X_NADD = 16'h0000;
`endif

  int          nchk = 0;
  int          nfail = 0;
  int          nret = 0;
  int          bp_base;
  logic        rnd_rdy;
  logic [17:0] exq [$];
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;
  logic        rs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s (beat %0d): observed %0h expected %0h", tag, nret, obs, exp);
    end
  endtask

  // Expected tuple is {ovf, cout, sum} from a full-width reference sum.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
    logic [15:0] bp;
    logic [16:0] full;
    logic        ov;
    logic [15:0] s;
    bp   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + {16'b0, (ms | mc)};
    ov   = (ma[15] == bp[15]) && (full[15] != ma[15]);
    s    = full[15:0];
`ifdef ADDSUB_SAT_EN
    if (ov) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, full[16], s};
  endfunction

  task automatic retire();
    logic [17:0] e;
    if (exq.size() == 0) begin
      check("unexpected_out", 32'd1, 32'd0);
    end else begin
      e = exq.pop_front();
      check("sum", 32'(sum), 32'(e[15:0]));
      check("cout", 32'(cout), 32'(e[16]));
      check("ovf", 32'(ovf), 32'(e[17]));
      nret++;
    end
  endtask

  // Sample on the falling edge; retire whatever handshakes on the next rising edge.
  task automatic half();
    @(negedge clk);
    if (!rst && out_valid && out_ready) retire();
  endtask

  task automatic step();
    half();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic ts, input logic [17:0] te);
    bit done;
    done = 1'b0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      half();
      if (in_ready) begin
        exq.push_back(te);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && exq.size() != 0; n++) step();
    step();
    check("drain_empty", 32'(exq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; rnd_rdy = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_flags", 32'({cout, ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Wrap with exact latency.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      half();
      check("latency_valid", 32'(out_valid), 32'(n == 4));
      @(posedge clk);
      #1;
    end
    step();

    // Back-to-back directed corners.
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, X_PADD});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h1234, 16'h1234, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000});
    send(16'h00FF, 16'h0F01, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1001});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, X_NSUB});
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, X_NADD});
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 16'hFFFF});
    drain();

    // Backpressure: 8 beats a=i, b=3i; hold out_ready low for 2 cycles after the first result.
    bp_base = nret;
    for (int j = 0; j < 5; j++)
      send(16'(j + 1), 16'(3 * (j + 1)), 1'b0, 1'b0, {2'b00, 16'(4 * (j + 1))});
    out_ready = 1'b0;
    a = 16'd6; b = 16'd18;
    for (int h = 0; h < 2; h++) begin
      half();
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'd8);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int j = 5; j < 8; j++)
      send(16'(j + 1), 16'(3 * (j + 1)), 1'b0, 1'b0, {2'b00, 16'(4 * (j + 1))});
    drain();
    check("bp_count", 32'(nret - bp_base), 32'd8);

    // Reset mid-flight.
    send(16'h0100, 16'h0001, 1'b0, 1'b0, {2'b00, 16'h0101});
    send(16'h0200, 16'h0002, 1'b0, 1'b0, {2'b00, 16'h0202});
    send(16'h0300, 16'h0003, 1'b0, 1'b0, {2'b00, 16'h0303});
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exq.delete();
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      half();
      check("no_stale", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Random operands with random consumer stalls and input gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        step();
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
